// File: rtl/jelly_bean_taster_mc.sv
// ----------------------------------------------------------------------------
// jelly_bean_taster_mc
//
// Multi-channel jelly bean tasting engine. Each of NUM_CH request channels
// owns a FIFO_DEPTH-entry request FIFO. A round-robin arbiter pops one request
// per cycle into a one-slot execute stage. The execute stage updates the shared
// recipe register and the yummy/yucky statistics, then returns the taste to
// the requesting channel.
//
// Pipeline:
//   p0: arbitration and FIFO pop.
//   p1: the granted request executes; results register at the end of p1.
// A request captured at edge t with no contention shows its result after
// edge t+2.
//
// Ports:
//   clk            clock, all logic on posedge
//   rst_n          asynchronous active-low reset
//   ch_flavor      3 bits per channel (0 none, 1 apple, 2 blueberry,
//                  3 bubble gum, 4 chocolate, 5..7 treated as non-chocolate)
//   ch_color       2 bits per channel (0 red, 1 green, 2 blue)
//   ch_sugar_free  1 bit per channel
//   ch_sour        1 bit per channel
//   ch_command     2 bits per channel (0 no-op, 1 read, 2 write, 3 clear)
//   ch_busy        channel FIFO full; a request offered now is rejected
//   ch_taste       2 bits per channel, last result (0 unknown, 1 yummy, 2 yucky)
//   ch_taste_vld   one-cycle pulse when the matching ch_taste field updates
//   yummy_cnt      saturating count of yummy writes
//   yucky_cnt      saturating count of yucky writes
//   drop_cnt       saturating count of rejected requests
//                  (present only when JELLY_BEAN_DROP_CNT_EN is defined)
//
// Build option: define JELLY_BEAN_DROP_CNT_EN to add drop_cnt. Without it,
// rejected requests are silently dropped.
// ----------------------------------------------------------------------------
module jelly_bean_taster_mc #(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3*NUM_CH-1:0] ch_flavor,
    input  logic [2*NUM_CH-1:0] ch_color,
    input  logic [NUM_CH-1:0]   ch_sugar_free,
    input  logic [NUM_CH-1:0]   ch_sour,
    input  logic [2*NUM_CH-1:0] ch_command,
    output logic [NUM_CH-1:0]   ch_busy,
    output logic [2*NUM_CH-1:0] ch_taste,
    output logic [NUM_CH-1:0]   ch_taste_vld,
    output logic [CNT_W-1:0]    yummy_cnt,
    output logic [CNT_W-1:0]    yucky_cnt
`ifdef JELLY_BEAN_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]    drop_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CH_W  = $clog2(NUM_CH);
    // NUM_CH <= 8, so a per-cycle drop tally fits in 4 bits.
    localparam int SUM_W = CNT_W + 4;

    localparam logic [PTR_W:0]  FILL_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NUM_CH - 1);

    localparam logic [1:0] CMD_NOP   = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;
    localparam logic [1:0] CMD_CLEAR = 2'd3;

    localparam logic [2:0] FLV_CHOC = 3'd4;

    localparam logic [1:0] TASTE_UNKNOWN = 2'd0;
    localparam logic [1:0] TASTE_YUMMY   = 2'd1;
    localparam logic [1:0] TASTE_YUCKY   = 2'd2;

    typedef struct packed {
        logic [2:0] flavor;
        logic [1:0] color;
        logic       sugar_free;
        logic       sour;
        logic [1:0] command;
    } req_t;

    // Saturating add of a small increment onto a statistics counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [3:0]       b);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b);
        if (sum > SUM_W'({CNT_W{1'b1}})) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    req_t             fifo_mem [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr   [NUM_CH];
    logic [PTR_W-1:0] rd_ptr   [NUM_CH];
    logic [PTR_W:0]   fill     [NUM_CH];
    req_t             in_req   [NUM_CH];
    req_t             head     [NUM_CH];

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;

    logic            grant_vld;
    logic [CH_W-1:0] grant_ch;
    req_t            grant_req;
    logic [CH_W-1:0] rr_ptr;

    logic            vld_p1;
    logic [CH_W-1:0] ch_p1;
    req_t            req_p1;

    logic [1:0] taste_new;
    logic [1:0] recipe_taste;
    logic [6:0] recipe_bean;

    // ---- Stage p0: enqueue, arbitration, pop -------------------------------
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            in_req[i] = {ch_flavor[3*i +: 3], ch_color[2*i +: 2],
                         ch_sugar_free[i], ch_sour[i], ch_command[2*i +: 2]};
            head[i]   = fifo_mem[i][rd_ptr[i]];
            full[i]   = (fill[i] == FILL_FULL);
            empty[i]  = (fill[i] == '0);
            // Busy is the registered full state, so a pop in the same cycle
            // does not open a slot for this cycle's request.
            push[i]   = (in_req[i].command != CMD_NOP) && !full[i];
        end
    end

    assign ch_busy = full;

    // Priority starts at rr_ptr and wraps; the first non-empty channel wins.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            for (int j = 0; j < NUM_CH; j++) begin
                if (!grant_vld && (j == idx) && !empty[j]) begin
                    grant_vld = 1'b1;
                    grant_ch  = CH_W'(j);
                end
            end
        end
    end

    always_comb begin
        grant_req = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            pop[j] = grant_vld && (grant_ch == CH_W'(j));
            if (grant_ch == CH_W'(j)) begin
                grant_req = head[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr[i]] <= in_req[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                fill[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                fill[i] <= fill[i] + {{PTR_W{1'b0}}, push[i]}
                                   - {{PTR_W{1'b0}}, pop[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= grant_vld;
            if (grant_vld) begin
                rr_ptr <= (grant_ch == CH_LAST) ? '0 : grant_ch + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        ch_p1  <= grant_ch;
        req_p1 <= grant_req;
    end

    // ---- Stage p1: execute granted request, register results ---------------
    always_comb begin
        taste_new = TASTE_UNKNOWN;
        case (req_p1.command)
            CMD_WRITE: taste_new = ((req_p1.flavor == FLV_CHOC) && req_p1.sour)
                                   ? TASTE_YUCKY : TASTE_YUMMY;
            CMD_READ:  taste_new = recipe_taste;
            default:   taste_new = TASTE_UNKNOWN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_taste     <= '0;
            ch_taste_vld <= '0;
            yummy_cnt    <= '0;
            yucky_cnt    <= '0;
            recipe_taste <= TASTE_UNKNOWN;
        end else begin
            ch_taste_vld <= '0;
            if (vld_p1) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_p1 == CH_W'(i)) begin
                        ch_taste[2*i +: 2] <= taste_new;
                        ch_taste_vld[i]    <= 1'b1;
                    end
                end
                case (req_p1.command)
                    CMD_WRITE: begin
                        recipe_taste <= taste_new;
                        if (taste_new == TASTE_YUCKY) begin
                            yucky_cnt <= sat_add(yucky_cnt, 4'd1);
                        end else begin
                            yummy_cnt <= sat_add(yummy_cnt, 4'd1);
                        end
                    end
                    CMD_CLEAR: begin
                        yummy_cnt    <= '0;
                        yucky_cnt    <= '0;
                        recipe_taste <= TASTE_UNKNOWN;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1 && (req_p1.command == CMD_WRITE)) begin
            recipe_bean <= {req_p1.flavor, req_p1.color, req_p1.sugar_free,
                            req_p1.sour};
        end
    end

`ifdef JELLY_BEAN_DROP_CNT_EN
    logic [3:0] drop_n;

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((ch_command[2*i +: 2] != CMD_NOP) && full[i]) begin
                drop_n = drop_n + 4'd1;
            end
        end
    end

    // A CLEAR executing this cycle zeroes the count; drops seen in the same
    // cycle are still counted on top of the zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (vld_p1 && (req_p1.command == CMD_CLEAR)) begin
            drop_cnt <= sat_add('0, drop_n);
        end else begin
            drop_cnt <= sat_add(drop_cnt, drop_n);
        end
    end
`endif

endmodule

// File: tb/tb_jelly_bean_taster_mc.sv
module tb_jelly_bean_taster_mc;

    localparam int NUM_CH     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 8;
    localparam int CNT2_W     = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [3*NUM_CH-1:0] ch_flavor;
    logic [2*NUM_CH-1:0] ch_color;
    logic [NUM_CH-1:0]   ch_sugar_free;
    logic [NUM_CH-1:0]   ch_sour;
    logic [2*NUM_CH-1:0] ch_command;

    logic [NUM_CH-1:0]   ch_busy,  busy2;
    logic [2*NUM_CH-1:0] ch_taste, taste2;
    logic [NUM_CH-1:0]   ch_taste_vld, vld2;
    logic [CNT_W-1:0]    yummy_cnt, yucky_cnt;
    logic [CNT2_W-1:0]   yummy2, yucky2;
`ifdef JELLY_BEAN_DROP_CNT_EN
    logic [CNT_W-1:0]    drop_cnt;
    logic [CNT2_W-1:0]   drop2;
`endif

    int checks = 0;
    int errors = 0;

    jelly_bean_taster_mc #(.NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_flavor(ch_flavor), .ch_color(ch_color), .ch_sugar_free(ch_sugar_free),
        .ch_sour(ch_sour), .ch_command(ch_command),
        .ch_busy(ch_busy), .ch_taste(ch_taste), .ch_taste_vld(ch_taste_vld),
        .yummy_cnt(yummy_cnt), .yucky_cnt(yucky_cnt)
`ifdef JELLY_BEAN_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    jelly_bean_taster_mc #(.NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT2_W)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .ch_flavor(ch_flavor), .ch_color(ch_color), .ch_sugar_free(ch_sugar_free),
        .ch_sour(ch_sour), .ch_command(ch_command),
        .ch_busy(busy2), .ch_taste(taste2), .ch_taste_vld(vld2),
        .yummy_cnt(yummy2), .yucky_cnt(yucky2)
`ifdef JELLY_BEAN_DROP_CNT_EN
        , .drop_cnt(drop2)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Per-channel queues of pending requests, one request in flight, and raw
    // (unsaturated) statistics since the last reset/CLEAR.
    typedef struct packed {
        bit [2:0] flavor;
        bit       sour;
        bit [1:0] command;
    } mreq_t;

    mreq_t              q [NUM_CH][$];
    bit                 fl_vld;
    mreq_t              fl_req;
    int                 fl_ch;
    int                 rr;
    bit [1:0]           m_recipe;
    bit [2*NUM_CH-1:0]  m_taste;
    bit [NUM_CH-1:0]    m_vld;
    int                 m_yummy, m_yucky, m_drop;
    int                 g;
    int                 c;
    bit [1:0]           t;
    bit [1:0]           cmd;
    bit                 was_full [NUM_CH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) q[i].delete();
            fl_vld   = 1'b0;
            rr       = 0;
            m_recipe = 2'd0;
            m_taste  = '0;
            m_vld    = '0;
            m_yummy  = 0;
            m_yucky  = 0;
            m_drop   = 0;
        end else begin
            m_vld = '0;
            if (fl_vld) begin
                case (fl_req.command)
                    2'd2: begin
                        t = (fl_req.flavor == 3'd4 && fl_req.sour) ? 2'd2 : 2'd1;
                        m_recipe = t;
                        if (t == 2'd2) m_yucky++;
                        else           m_yummy++;
                    end
                    2'd1: t = m_recipe;
                    default: begin
                        t        = 2'd0;
                        m_recipe = 2'd0;
                        m_yummy  = 0;
                        m_yucky  = 0;
                        m_drop   = 0;
                    end
                endcase
                m_taste[2*fl_ch +: 2] = t;
                m_vld[fl_ch] = 1'b1;
            end
            for (int i = 0; i < NUM_CH; i++) was_full[i] = (q[i].size() == FIFO_DEPTH);
            g = -1;
            for (int k = 0; k < NUM_CH; k++) begin
                c = (rr + k) % NUM_CH;
                if (g < 0 && q[c].size() > 0) g = c;
            end
            fl_vld = (g >= 0);
            if (g >= 0) begin
                fl_req = q[g].pop_front();
                fl_ch  = g;
                rr     = (g + 1) % NUM_CH;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                cmd = ch_command[2*i +: 2];
                if (cmd != 2'd0) begin
                    if (was_full[i]) m_drop++;
                    else q[i].push_back({ch_flavor[3*i +: 3], ch_sour[i], cmd});
                end
            end
        end
    end

    function automatic int sat(input int raw, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (raw > mx) ? mx : raw;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_busy();
        logic [NUM_CH-1:0] b;
        for (int i = 0; i < NUM_CH; i++) b[i] = (q[i].size() == FIFO_DEPTH);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model-vs-DUT comparison on every cycle, away from the active edge.
    always @(negedge clk) begin
        check("busy",   32'(ch_busy),      32'(exp_busy()));
        check("taste",  32'(ch_taste),     32'(m_taste));
        check("vld",    32'(ch_taste_vld), 32'(m_vld));
        check("yummy",  32'(yummy_cnt),    sat(m_yummy, CNT_W));
        check("yucky",  32'(yucky_cnt),    sat(m_yucky, CNT_W));
        check("busy2",  32'(busy2),        32'(exp_busy()));
        check("taste2", 32'(taste2),       32'(m_taste));
        check("vld2",   32'(vld2),         32'(m_vld));
        check("yummy2", 32'(yummy2),       sat(m_yummy, CNT2_W));
        check("yucky2", 32'(yucky2),       sat(m_yucky, CNT2_W));
`ifdef JELLY_BEAN_DROP_CNT_EN
        check("drop",   32'(drop_cnt),     sat(m_drop, CNT_W));
        check("drop2",  32'(drop2),        sat(m_drop, CNT2_W));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic idle_all();
        ch_flavor     = '0;
        ch_color      = '0;
        ch_sugar_free = '0;
        ch_sour       = '0;
        ch_command    = '0;
    endtask

    task automatic req(input int ch, input int cm, input int flv, input bit sr);
        ch_command[2*ch +: 2] = 2'(cm);
        ch_flavor[3*ch +: 3]  = 3'(flv);
        ch_sour[ch]           = sr;
        ch_color[2*ch +: 2]   = 2'(ch % 3);
        ch_sugar_free[ch]     = ch[0];
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_all();
        #1 rst_n = 1'b0;
        step(2);
        check("rst_busy",  32'(ch_busy), 0);
        check("rst_vld",   32'(ch_taste_vld), 0);
        check("rst_taste", 32'(ch_taste), 0);
        check("rst_yummy", 32'(yummy_cnt), 0);
        rst_n = 1'b1;
        step(1);

        // Chocolate + sour write on ch0: yucky after two edges.
        req(0, 2, 4, 1'b1);
        step(1);
        idle_all();
        step(2);
        check("t1_taste0", 32'(ch_taste[1:0]), 2);
        check("t1_vld",    32'(ch_taste_vld), 32'b0001);
        check("t1_yucky",  32'(yucky_cnt), 1);
        check("t1_yummy",  32'(yummy_cnt), 0);
        step(1);
        check("t1_vld_off", 32'(ch_taste_vld), 0);
        check("t1_hold",    32'(ch_taste[1:0]), 2);

        // ch2 writes apple, ch1 reads it back one edge later.
        req(2, 2, 1, 1'b0);
        step(1);
        idle_all();
        req(1, 1, 0, 1'b0);
        step(1);
        idle_all();
        step(1);
        check("t2_taste2", 32'(ch_taste[5:4]), 1);
        check("t2_vld2",   32'(ch_taste_vld), 32'b0100);
        step(1);
        check("t2_taste1", 32'(ch_taste[3:2]), 1);
        check("t2_vld1",   32'(ch_taste_vld), 32'b0010);
        check("t2_yummy",  32'(yummy_cnt), 1);

        // ch3 read moves the round-robin pointer back to channel 0.
        req(3, 1, 0, 1'b0);
        step(1);
        idle_all();
        step(2);
        check("rr_taste3", 32'(ch_taste[7:6]), 1);
        check("rr_vld3",   32'(ch_taste_vld), 32'b1000);

        // All four channels write together; flavor 7 with sour is still yummy.
        req(0, 2, 1, 1'b0);
        req(1, 2, 2, 1'b0);
        req(2, 2, 3, 1'b1);
        req(3, 2, 7, 1'b1);
        step(1);
        idle_all();
        step(2);
        check("t3_vld_a", 32'(ch_taste_vld), 32'b0001);
        step(1);
        check("t3_vld_b", 32'(ch_taste_vld), 32'b0010);
        step(1);
        check("t3_vld_c", 32'(ch_taste_vld), 32'b0100);
        step(1);
        check("t3_vld_d",  32'(ch_taste_vld), 32'b1000);
        check("t3_yummy",  32'(yummy_cnt), 5);
        check("t3_taste3", 32'(ch_taste[7:6]), 1);

        // Every channel writes for five edges; ch3 fills first, its 5th is dropped.
        for (int n = 0; n < 5; n++) begin
            req(0, 2, 4, 1'b0);
            req(1, 2, 1, 1'b0);
            req(2, 2, 1, 1'b0);
            req(3, 2, 1, 1'b0);
            step(1);
            if (n == 2) check("t4_busy_a", 32'(ch_busy), 0);
            if (n == 3) check("t4_busy_b", 32'(ch_busy), 32'b1000);
            if (n == 4) begin
                check("t4_busy_c", 32'(ch_busy), 32'b0111);
`ifdef JELLY_BEAN_DROP_CNT_EN
                check("t4_drop", 32'(drop_cnt), 1);
`endif
            end
        end
        idle_all();
        step(20);
        check("t4_yummy", 32'(yummy_cnt), 24);
        check("t4_yucky", 32'(yucky_cnt), 1);
        check("t4_busy",  32'(ch_busy), 0);

        // Three writes, then CLEAR on ch3, then READ on ch0.
        req(0, 2, 1, 1'b0);
        req(1, 2, 1, 1'b0);
        req(2, 2, 1, 1'b0);
        step(1);
        idle_all();
        req(3, 3, 0, 1'b0);
        step(1);
        idle_all();
        req(0, 1, 0, 1'b0);
        step(1);
        idle_all();
        step(2);
        check("t5_yummy_pre",  32'(yummy_cnt), 27);
        check("t5_yummy2_sat", 32'(yummy2), 3);
        step(1);
        check("t5_clr_yummy", 32'(yummy_cnt), 0);
        check("t5_clr_yucky", 32'(yucky_cnt), 0);
        check("t5_clr_taste", 32'(ch_taste[7:6]), 0);
        check("t5_clr_vld",   32'(ch_taste_vld), 32'b1000);
`ifdef JELLY_BEAN_DROP_CNT_EN
        check("t5_clr_drop",  32'(drop_cnt), 0);
`endif
        step(1);
        check("t5_rd_taste", 32'(ch_taste[1:0]), 0);
        check("t5_rd_vld",   32'(ch_taste_vld), 32'b0001);

        // Five yummy writes after the clear: narrow counter pins at 3.
        for (int n = 0; n < 5; n++) begin
            req(0, 2, 1, 1'b0);
            step(1);
        end
        idle_all();
        step(2);
        check("sat_yummy",  32'(yummy_cnt), 5);
        check("sat_yummy2", 32'(yummy2), 3);

        // Reset asserted with three requests queued.
        req(1, 2, 4, 1'b1);
        req(2, 2, 4, 1'b1);
        req(3, 2, 4, 1'b1);
        step(1);
        idle_all();
        #2 rst_n = 1'b0;
        #1;
        check("t6_taste",  32'(ch_taste), 0);
        check("t6_vld",    32'(ch_taste_vld), 0);
        check("t6_busy",   32'(ch_busy), 0);
        check("t6_yummy",  32'(yummy_cnt), 0);
        check("t6_yummy2", 32'(yummy2), 0);
        step(2);
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            step(1);
            check("t6_post_vld",   32'(ch_taste_vld), 0);
            check("t6_post_busy",  32'(ch_busy), 0);
            check("t6_post_yucky", 32'(yucky_cnt), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
